// File: rtl/shift_left_seq_if.sv
// shift_left_seq_if: operand/result bundle for the multi-cycle left shifter.
// The master side (pipeline control) issues start with an operand, shift
// amount and mode; the slave side (the shifter) answers with busy, done and
// the result register.
interface shift_left_seq_if;
  logic        start;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic        Rot;
  logic        busy;
  logic        done;
  logic [15:0] Out;

  modport master (
    output start,
    output In,
    output Cnt,
    output Rot,
    input  busy,
    input  done,
    input  Out
  );

  modport slave (
    input  start,
    input  In,
    input  Cnt,
    input  Rot,
    output busy,
    output done,
    output Out
  );
endinterface

// File: rtl/shift_left_seq.sv
// shift_left_seq: multi-cycle 16-bit left shifter/rotator for the EX stage.
// Shifts 2 bits per cycle (1 bit on a final odd step) and raises a one-cycle
// done strobe when the result register holds the final value.
// Optional feature macro: SHL_ROTATE_EN. When defined, the Rot input selects
// rotate-left; when undefined, the rotate datapath and mode register are
// removed and every operation is a logical (zero-fill) shift.
module shift_left_seq (
  input  logic               clk,
  input  logic               rst,
  shift_left_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q,  data_d;
  logic [3:0]  rem_q,   rem_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic [1:0]  fill2;
  logic        fill1;

`ifdef SHL_ROTATE_EN
  logic        mode_q,  mode_d;

  // Bits fed into the vacated LSBs: the MSBs leaving the word when rotating,
  // zeros otherwise.
  always_comb begin
    fill2 = mode_q ? data_q[15:14] : 2'b00;
    fill1 = mode_q ? data_q[15]    : 1'b0;
  end
`else
  logic        unused_rot;

  // Logical-only build: the mode input has no effect and the LSBs always
  // fill with zeros.
  always_comb begin
    fill2 = 2'b00;
    fill1 = 1'b0;
  end

  assign unused_rot = bus.Rot;
`endif

  // Next-state, datapath and decoded output computation. A start is honoured
  // only outside SHIFT, which allows a reload straight out of DONE.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
`ifdef SHL_ROTATE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          data_d  = bus.In;
          rem_d   = bus.Cnt;
`ifdef SHL_ROTATE_EN
          mode_d  = bus.Rot;
`endif
          state_d = (bus.Cnt == 4'd0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (rem_q >= 4'd2) begin
          data_d = {data_q[13:0], fill2};
          rem_d  = rem_q - 4'd2;
        end else begin
          data_d = {data_q[14:0], fill1};
          rem_d  = 4'd0;
        end
        state_d = (rem_d == 4'd0) ? DONE : SHIFT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset aborts any operation without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 16'h0000;
      rem_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHL_ROTATE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SHL_ROTATE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Out  = data_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// tb_shift_left_seq: directed, table-driven bench for shift_left_seq, with
// hand-written sequences for back-to-back starts, ignored starts during
// SHIFT, and reset mid-operation. Honours SHL_ROTATE_EN for rotate vectors.
module tb_shift_left_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  shift_left_seq_if bus ();

  shift_left_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef SHL_ROTATE_EN
  localparam bit RotOn = 1'b1;
`else
  localparam bit RotOn = 1'b0;
`endif

  typedef struct {
    logic [15:0] inVal;
    logic [3:0]  cnt;
    logic        rot;
    logic [15:0] expOut;
    int          expLat;
    int          expBusy;
  } vec_t;

  vec_t vecs [8];

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Present one start pulse; returns #1 after the accepting edge (cycle 1).
  task automatic applyStimulus(input logic [15:0] inVal, input logic [3:0] cnt,
                               input logic rot);
    @(negedge clk);
    bus.start = 1'b1;
    bus.In    = inVal;
    bus.Cnt   = cnt;
    bus.Rot   = rot;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles since the accepting edge and
  // busy cycles along the way. Latency -1 means done never arrived.
  task automatic waitDone(output int lat, output int busyCnt, output bit overlap);
    lat     = 1;
    busyCnt = 0;
    overlap = 1'b0;
    while (!bus.done && lat <= 20) begin
      if (bus.busy) busyCnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.done && bus.busy) overlap = 1'b1;
    if (!bus.done) lat = -1;
  endtask

  initial begin
    int lat;
    int busyCnt;
    bit overlap;
    int doneSeen;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.In    = 16'h0000;
    bus.Cnt   = 4'd0;
    bus.Rot   = 1'b0;

    vecs[0] = '{16'h0001, 4'd15, 1'b0, 16'h8000, 9, 8};
    vecs[1] = '{16'hABCD, 4'd0,  1'b0, 16'hABCD, 1, 0};
    vecs[2] = '{16'h0001, 4'd3,  1'b0, 16'h0008, 3, 2};
    vecs[3] = '{16'hF00F, 4'd4,  1'b0, 16'h00F0, 3, 2};
    vecs[4] = '{16'hF00F, 4'd4,  1'b1, RotOn ? 16'h00FF : 16'h00F0, 3, 2};
    vecs[5] = '{16'h8001, 4'd1,  1'b1, RotOn ? 16'h0003 : 16'h0002, 2, 1};
    vecs[6] = '{16'h1234, 4'd2,  1'b0, 16'h48D0, 2, 1};
    vecs[7] = '{16'hFFFF, 4'd15, 1'b1, RotOn ? 16'hFFFF : 16'h8000, 9, 8};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset_out",  {16'd0, bus.Out},  32'h0000);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].inVal, vecs[i].cnt, vecs[i].rot);
      waitDone(lat, busyCnt, overlap);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d_busy_cycles", i), busyCnt, vecs[i].expBusy);
      checkOutput($sformatf("v%0d_busy_done_overlap", i), {31'd0, overlap}, 32'd0);
      checkOutput($sformatf("v%0d_out", i), {16'd0, bus.Out}, {16'd0, vecs[i].expOut});
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_done_one_cycle", i), {31'd0, bus.done}, 32'd0);
      checkOutput($sformatf("v%0d_out_hold", i), {16'd0, bus.Out}, {16'd0, vecs[i].expOut});
    end

    // Back-to-back: reload in the DONE cycle with no idle gap.
    applyStimulus(16'h0003, 4'd2, 1'b0);
    waitDone(lat, busyCnt, overlap);
    checkOutput("b2b_first_latency", lat, 2);
    checkOutput("b2b_first_out", {16'd0, bus.Out}, 32'h000C);
    bus.start = 1'b1;
    bus.In    = 16'h0001;
    bus.Cnt   = 4'd1;
    bus.Rot   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2b_no_gap_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("b2b_no_gap_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("b2b_second_done", {31'd0, bus.done}, 32'd1);
    checkOutput("b2b_second_out", {16'd0, bus.Out}, 32'h0002);

    // Start pulsed during SHIFT must be ignored.
    applyStimulus(16'h0001, 4'd4, 1'b0);
    bus.start = 1'b1;
    bus.In    = 16'hFFFF;
    bus.Cnt   = 4'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(lat, busyCnt, overlap);
    checkOutput("ignore_latency", lat, 2);
    checkOutput("ignore_out", {16'd0, bus.Out}, 32'h0010);
    @(posedge clk);
    #1;

    // Reset in the second SHIFT cycle, with a competing start.
    applyStimulus(16'h1234, 4'd10, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_mid_busy_before", {31'd0, bus.busy}, 32'd1);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.In    = 16'hFFFF;
    bus.Cnt   = 4'd0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_mid_out",  {16'd0, bus.Out},  32'h0000);
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done) doneSeen++;
      @(posedge clk);
      #1;
    end
    checkOutput("rst_mid_no_done", doneSeen, 0);
    applyStimulus(16'h4000, 4'd1, 1'b0);
    waitDone(lat, busyCnt, overlap);
    checkOutput("after_rst_latency", lat, 2);
    checkOutput("after_rst_out", {16'd0, bus.Out}, 32'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
